da2_dac_tx: RTL

//  Serial transmitter for a dual 12-bit DAC121S101 Pmod (DA2): SYNC, SCLK, DINA, DINB.

---
 rtl/da2_dac_tx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/da2_dac_tx.sv
// Dual-channel DAC121S101 (Pmod DA2) serial transmitter: one 12-bit code pair per handshake.
// Build macro DA2_RAMP_TEST_EN replaces the handshake with an internal self-accepting sawtooth.
module da2_dac_tx #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned GAP_CYC = 8
) (
   input  logic        clk100,
   input  logic        RESET,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [11:0] data_a,
   input  logic [11:0] data_b,
   input  logic [1:0]  pd_mode,
   output logic        busy,
   output logic        done,
   output logic        SYNC,
   output logic        SCLK,
   output logic        DINA,
   output logic        DINB
);

   typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

   localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
   localparam logic [7:0] GapLast = 8'(GAP_CYC - 1);

   state_e      state_q;
   logic [7:0]  div_cnt_q;
   logic [4:0]  bit_cnt_q;
   logic [15:0] sh_a_q, sh_b_q;
   logic        sync_q, sclk_q, dina_q, dinb_q, ready_q, busy_q, done_q;

   logic        accept;
   logic [11:0] cap_a, cap_b;
   logic [1:0]  cap_pd;
   logic [15:0] word_a, word_b;

`ifdef DA2_RAMP_TEST_EN
   logic [11:0] ramp_q;
   logic        unused_inputs;

   assign unused_inputs = ^{in_valid, data_a, data_b, pd_mode};
   assign accept        = ready_q;
   assign cap_a         = ramp_q;
   assign cap_b         = ~ramp_q;
   assign cap_pd        = 2'b00;

   always_ff @(posedge clk100 or negedge RESET) begin
      if (!RESET) begin
         ramp_q <= '0;
      end else if (accept) begin
         ramp_q <= ramp_q + 12'd1;
      end
   end
`else
   assign accept = in_valid & ready_q;
   assign cap_a  = data_a;
   assign cap_b  = data_b;
   assign cap_pd = pd_mode;
`endif

   assign word_a = {2'b00, cap_pd, cap_a};
   assign word_b = {2'b00, cap_pd, cap_b};

   always_ff @(posedge clk100 or negedge RESET) begin
      if (!RESET) begin
         state_q   <= StIdle;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         sh_a_q    <= '0;
         sh_b_q    <= '0;
         sync_q    <= 1'b1;
         sclk_q    <= 1'b1;
         dina_q    <= 1'b0;
         dinb_q    <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  state_q   <= StShift;
                  ready_q   <= 1'b0;
                  busy_q    <= 1'b1;
                  sync_q    <= 1'b0;
                  sclk_q    <= 1'b1;
                  div_cnt_q <= '0;
                  bit_cnt_q <= '0;
                  sh_a_q    <= word_a;
                  sh_b_q    <= word_b;
                  dina_q    <= word_a[15];
                  dinb_q    <= word_b[15];
               end else begin
                  ready_q <= 1'b1;
               end
            end
            StShift: begin
               if (div_cnt_q == DivLast) begin
                  div_cnt_q <= '0;
                  if (sclk_q) begin
                     // Falling SCLK: the DAC samples DIN here.
                     sclk_q    <= 1'b0;
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end else if (bit_cnt_q == 5'd16) begin
                     state_q <= StGap;
                     sclk_q  <= 1'b1;
                     sync_q  <= 1'b1;
                     dina_q  <= 1'b0;
                     dinb_q  <= 1'b0;
                  end else begin
                     sclk_q <= 1'b1;
                     sh_a_q <= {sh_a_q[14:0], 1'b0};
                     sh_b_q <= {sh_b_q[14:0], 1'b0};
                     dina_q <= sh_a_q[14];
                     dinb_q <= sh_b_q[14];
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + 8'd1;
               end
            end
            StGap: begin
               if (div_cnt_q == GapLast) begin
                  state_q   <= StIdle;
                  div_cnt_q <= '0;
                  done_q    <= 1'b1;
                  ready_q   <= 1'b1;
                  busy_q    <= 1'b0;
               end else begin
                  div_cnt_q <= div_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign in_ready = ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign SYNC     = sync_q;
   assign SCLK     = sclk_q;
   assign DINA     = dina_q;
   assign DINB     = dinb_q;

endmodule
